// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    BR_EX = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating stall-cycle and taken-branch counter pair.
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             taken_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] branches_taken
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      branches_taken <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (taken_inc && (branches_taken != '1))
        branches_taken <= branches_taken + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Load-use / branch hazard FSM driving PC, IF/ID and ID/EX controls.
// Optional saturating performance counters under HAZARD_PERF_EN.
module pipe_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DATA_W = 32
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_is_branch,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              ex_mem_read,
  input  logic              ex_beq,
  input  logic              ex_bne,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_offset,
  output logic              hold_pc,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_offset
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  branches_taken
`endif
);

  hz_state_t state, next_state;
  logic      lu;
  logic      taken;

  assign lu = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign taken = (ex_beq && ex_zero) || (ex_bne && !ex_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Reset gates the outputs combinationally so they read 0 for the whole
  // assertion, not just from the next edge.
  always_comb begin
    next_state   = state;
    hold_pc      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_redirect  = 1'b0;
    pc_offset    = '0;
    if (!rst_n) begin
      next_state = RUN;
    end else if (freeze) begin
      hold_pc    = 1'b1;
      if_id_hold = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (lu) begin
            hold_pc      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_is_branch) begin
            hold_pc     = 1'b1;
            if_id_flush = 1'b1;
            next_state  = BR_EX;
          end
        end
        BR_EX: begin
          next_state = RUN;
          if (taken) begin
            pc_redirect = 1'b1;
            pc_offset   = ex_offset;
            if_id_flush = 1'b1;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_inc      (hold_pc && !freeze),
    .taken_inc      (pc_redirect),
    .stall_cycles   (stall_cycles),
    .branches_taken (branches_taken)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer with an expected-output scoreboard.
module tb_pipe_hazard_sequencer;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
`ifdef HAZARD_PERF_EN
  localparam int unsigned CNT_W  = 16;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              freeze;
  logic [REG_W-1:0]  id_rs, id_rt, ex_rt;
  logic              id_is_branch, ex_mem_read, ex_beq, ex_bne, ex_zero;
  logic [DATA_W-1:0] ex_offset;
  logic              hold_pc, if_id_hold, if_id_flush, id_ex_bubble, pc_redirect;
  logic [DATA_W-1:0] pc_offset;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  stall_cycles, branches_taken;
`endif

  typedef struct packed {
    logic [4:0]        flags; // hold_pc, if_id_hold, if_id_flush, id_ex_bubble, pc_redirect
    logic [DATA_W-1:0] offset;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    checks = 0;
  int    errors = 0;

  pipe_hazard_sequencer #(
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .freeze         (freeze),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_is_branch   (id_is_branch),
    .ex_rt          (ex_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_beq         (ex_beq),
    .ex_bne         (ex_bne),
    .ex_zero        (ex_zero),
    .ex_offset      (ex_offset),
    .hold_pc        (hold_pc),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .pc_redirect    (pc_redirect),
    .pc_offset      (pc_offset)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .branches_taken (branches_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    freeze = 0; id_rs = 0; id_rt = 0; ex_rt = 0; id_is_branch = 0;
    ex_mem_read = 0; ex_beq = 0; ex_bne = 0; ex_zero = 0; ex_offset = '0;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] flags,
                            input logic [DATA_W-1:0] off);
    sb.push_back('{flags: flags, offset: off});
    tags.push_back(tag);
  endtask

  // Inputs are already driven; compare combinational outputs at negedge,
  // then advance past the next rising edge.
  task automatic check_and_step();
    exp_t  e;
    exp_t  obs;
    string t;
    @(negedge clk);
    e   = sb.pop_front();
    t   = tags.pop_front();
    obs = '{flags: {hold_pc, if_id_hold, if_id_flush, id_ex_bubble, pc_redirect},
            offset: pc_offset};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed flags=%b off=%h expected flags=%b off=%h",
             t, obs.flags, obs.offset, e.flags, e.offset);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    // Hazardous inputs during reset must not reach the outputs.
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_is_branch = 1;
    #2;
    expect_out("reset_outputs", 5'b00000, '0); check_and_step();
`ifdef HAZARD_PERF_EN
    checks++;
    assert ({stall_cycles, branches_taken} === '0) else begin
      errors++;
      $error("FAIL reset_counters observed %h/%h expected 0/0", stall_cycles, branches_taken);
    end
`endif
    idle_inputs();
    rst_n = 1;
    #1;
    expect_out("idle", 5'b00000, '0); check_and_step();

    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    expect_out("lu_rs", 5'b11010, '0); check_and_step();
    idle_inputs();
    expect_out("after_lu", 5'b00000, '0); check_and_step();
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    expect_out("lu_r0", 5'b00000, '0); check_and_step();
    ex_mem_read = 1; ex_rt = 3; id_rt = 3; id_rs = 4;
    expect_out("lu_rt", 5'b11010, '0); check_and_step();
    ex_mem_read = 0;
    expect_out("no_load_match", 5'b00000, '0); check_and_step();

    // taken beq
    idle_inputs(); id_is_branch = 1;
    expect_out("beq_enter", 5'b10100, '0); check_and_step();
    idle_inputs(); id_is_branch = 1; ex_beq = 1; ex_zero = 1; ex_offset = 32'h10;
    expect_out("beq_taken", 5'b00101, 32'h10); check_and_step();
    idle_inputs(); ex_offset = 32'h10;
    expect_out("beq_after", 5'b00000, '0); check_and_step();

    // not-taken bne, lu inputs ignored in BR_EX
    id_is_branch = 1;
    expect_out("bne_enter", 5'b10100, '0); check_and_step();
    idle_inputs(); ex_bne = 1; ex_zero = 1; ex_offset = 32'h20;
    ex_mem_read = 1; ex_rt = 9; id_rs = 9;
    expect_out("bne_not_taken", 5'b00000, '0); check_and_step();
    idle_inputs();
    expect_out("bne_after", 5'b00000, '0); check_and_step();

    // load feeding a branch
    id_is_branch = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    expect_out("lu_branch_stall", 5'b11010, '0); check_and_step();
    ex_mem_read = 0;
    expect_out("lu_branch_enter", 5'b10100, '0); check_and_step();
    idle_inputs(); ex_offset = 32'h30;
    expect_out("no_branch_flags", 5'b00000, '0); check_and_step();

    // freeze in BR_EX for 3 cycles, then taken bne with negative offset
    id_is_branch = 1;
    expect_out("frz_enter", 5'b10100, '0); check_and_step();
    idle_inputs(); freeze = 1; ex_bne = 1; ex_zero = 0; ex_offset = 32'hFFFF_FFF0;
    for (int i = 0; i < 3; i++) begin
      expect_out("frz_hold", 5'b11000, '0); check_and_step();
    end
    freeze = 0;
    expect_out("frz_release_taken", 5'b00101, 32'hFFFF_FFF0); check_and_step();
    idle_inputs();
    expect_out("frz_after", 5'b00000, '0); check_and_step();

    // freeze beats a load-use hazard in RUN
    freeze = 1; ex_mem_read = 1; ex_rt = 7; id_rt = 7;
    expect_out("frz_over_lu", 5'b11000, '0); check_and_step();
    idle_inputs();

    // reset while in BR_EX abandons the branch
    id_is_branch = 1;
    expect_out("rst_enter", 5'b10100, '0); check_and_step();
    idle_inputs(); ex_beq = 1; ex_zero = 1; ex_offset = 32'h40;
    #2 rst_n = 0;
    #1;
    expect_out("rst_in_brex", 5'b00000, '0); check_and_step();
`ifdef HAZARD_PERF_EN
    checks++;
    assert ({stall_cycles, branches_taken} === '0) else begin
      errors++;
      $error("FAIL rst_counters observed %h/%h expected 0/0", stall_cycles, branches_taken);
    end
`endif
    rst_n = 1;
    #1;
    expect_out("rst_release_run", 5'b00000, '0); check_and_step();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
